// File: rtl/dbg_apb_pkg.sv
// dbg_apb_pkg: shared FSM states, response codes and one-hot select helper for dbg_apb_master
package dbg_apb_pkg;

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} dbg_apb_state_e;

    localparam logic RSP_OK     = 1'b0;
    localparam logic RSP_ERR    = 1'b1;
    localparam int   MAX_SLAVES = 256;

    function automatic logic [MAX_SLAVES-1:0] onehot(input int unsigned idx, input int unsigned n);
        onehot = '0;
        if (idx < n && idx < MAX_SLAVES) onehot[idx[7:0]] = 1'b1;
    endfunction

endpackage

// File: rtl/dbg_apb_timeout_cnt.sv
// dbg_apb_timeout_cnt: ACCESS-phase wait counter; ports clk, rst, clear_i, inc_i, expired_o (ready still low on cycle TIMEOUT_CYCLES)
module dbg_apb_timeout_cnt #(
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic clk,
    input  logic rst,
    input  logic clear_i,
    input  logic inc_i,
    output logic expired_o
);

    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

    logic [CW-1:0] cnt_q;

    // cnt_q holds the number of ready-low ACCESS cycles already seen
    assign expired_o = cnt_q >= CW'(TIMEOUT_CYCLES - 1);

    always_ff @(posedge clk) begin
        if (rst || clear_i) cnt_q <= '0;
        else if (inc_i && !expired_o) cnt_q <= cnt_q + 1'b1;
    end

endmodule

// File: rtl/dbg_apb_master.sv
// dbg_apb_master: DAP-to-APB debug bridge; req_* in, rsp_* out, apb_* bus side; optional ACCESS timeout via DBG_APB_MASTER_TIMEOUT_EN
module dbg_apb_master
    import dbg_apb_pkg::*;
#(
    parameter  int NR_SLAVES      = 1,
    parameter  int ADDR_WIDTH     = 5,
    parameter  int WDATA_WIDTH    = 32,
    parameter  int RDATA_WIDTH    = 32,
    parameter  int TIMEOUT_CYCLES = 64,
    localparam int SLV_W          = NR_SLAVES > 1 ? $clog2(NR_SLAVES) : 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   req_valid,
    output logic                   req_ready,
    input  logic [SLV_W-1:0]       req_slave,
    input  logic [ADDR_WIDTH-1:0]  req_addr,
    input  logic                   req_wr_rd,
    input  logic [WDATA_WIDTH-1:0] req_wdata,
    output logic                   rsp_valid,
    input  logic                   rsp_ready,
    output logic [RDATA_WIDTH-1:0] rsp_rdata,
    output logic                   rsp_err,
    output logic [ADDR_WIDTH-1:0]  apb_addr,
    output logic [NR_SLAVES-1:0]   apb_sel,
    output logic                   apb_enable,
    output logic                   apb_wr_rd,
    output logic [WDATA_WIDTH-1:0] apb_wdata,
    input  logic                   apb_ready,
    input  logic [RDATA_WIDTH-1:0] apb_rdata
);

    if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES out of range 1..65535");
    end

    dbg_apb_state_e          state_q, state_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic                    wr_q, wr_d;
    logic [WDATA_WIDTH-1:0]  wdata_q, wdata_d;
    logic [NR_SLAVES-1:0]    sel_q, sel_d;
    logic                    en_q, en_d;
    logic                    rsp_valid_q, rsp_valid_d;
    logic [RDATA_WIDTH-1:0]  rsp_rdata_q, rsp_rdata_d;
    logic                    rsp_err_q, rsp_err_d;
    logic [MAX_SLAVES-1:0]   oh;
    logic                    timeout;

`ifdef DBG_APB_MASTER_TIMEOUT_EN
    dbg_apb_timeout_cnt #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timeout_cnt (
        .clk       (clk),
        .rst       (rst),
        .clear_i   (state_q == SETUP),
        .inc_i     (state_q == ACCESS && !apb_ready),
        .expired_o (timeout)
    );
`else
    assign timeout = 1'b0;
`endif

    assign oh         = onehot(32'(req_slave), NR_SLAVES);
    assign req_ready  = state_q == IDLE;
    assign rsp_valid  = rsp_valid_q;
    assign rsp_rdata  = rsp_rdata_q;
    assign rsp_err    = rsp_err_q;
    assign apb_addr   = addr_q;
    assign apb_sel    = sel_q;
    assign apb_enable = en_q;
    assign apb_wr_rd  = wr_q;
    assign apb_wdata  = wdata_q;

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        wr_d        = wr_q;
        wdata_d     = wdata_q;
        sel_d       = sel_q;
        en_d        = en_q;
        rsp_valid_d = rsp_valid_q;
        rsp_rdata_d = rsp_rdata_q;
        rsp_err_d   = rsp_err_q;
        case (state_q)
            IDLE: if (req_valid) begin
                addr_d  = req_addr;
                wr_d    = req_wr_rd;
                wdata_d = req_wdata;
                if (32'(req_slave) >= NR_SLAVES) begin
                    state_d     = RESP;
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = RSP_ERR;
                    rsp_rdata_d = '0;
                end else begin
                    state_d = SETUP;
                    sel_d   = oh[NR_SLAVES-1:0];
                end
            end
            SETUP: begin
                state_d = ACCESS;
                en_d    = 1'b1;
            end
            ACCESS: if (apb_ready || timeout) begin
                // ready on the final allowed cycle wins over the timeout
                state_d     = RESP;
                sel_d       = '0;
                en_d        = 1'b0;
                rsp_valid_d = 1'b1;
                rsp_err_d   = apb_ready ? RSP_OK : RSP_ERR;
                rsp_rdata_d = (apb_ready && !wr_q) ? apb_rdata : '0;
            end
            RESP: if (rsp_ready) begin
                state_d     = IDLE;
                rsp_valid_d = 1'b0;
                rsp_err_d   = RSP_OK;
                rsp_rdata_d = '0;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            addr_q      <= '0;
            wr_q        <= 1'b0;
            wdata_q     <= '0;
            sel_q       <= '0;
            en_q        <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= RSP_OK;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            wr_q        <= wr_d;
            wdata_q     <= wdata_d;
            sel_q       <= sel_d;
            en_q        <= en_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

endmodule

// File: tb/tb_dbg_apb_master.sv
// tb_dbg_apb_master: directed scoreboard bench for dbg_apb_master (3 slaves, timeout 4 when DBG_APB_MASTER_TIMEOUT_EN)
module tb_dbg_apb_master;

    localparam int NS = 3;
    localparam int TO = 4;

    typedef struct packed {
        logic        err;
        logic [31:0] rdata;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [1:0]  req_slave = '0;
    logic [4:0]  req_addr = '0;
    logic        req_wr_rd = 1'b0;
    logic [31:0] req_wdata = '0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic [4:0]  apb_addr;
    logic [2:0]  apb_sel;
    logic        apb_enable;
    logic        apb_wr_rd;
    logic [31:0] apb_wdata;
    logic        apb_ready = 1'b0;
    logic [31:0] apb_rdata = '0;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    dbg_apb_master #(
        .NR_SLAVES(NS), .ADDR_WIDTH(5), .WDATA_WIDTH(32), .RDATA_WIDTH(32), .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_slave(req_slave), .req_addr(req_addr),
        .req_wr_rd(req_wr_rd), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .apb_addr(apb_addr), .apb_sel(apb_sel), .apb_enable(apb_enable), .apb_wr_rd(apb_wr_rd),
        .apb_wdata(apb_wdata), .apb_ready(apb_ready), .apb_rdata(apb_rdata)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic req(input logic [1:0] s, input logic [4:0] a, input logic w, input logic [31:0] d,
                       input logic e, input logic [31:0] r, input bit push);
        req_valid = 1'b1;
        req_slave = s;
        req_addr  = a;
        req_wr_rd = w;
        req_wdata = d;
        if (push) sb.push_back('{err: e, rdata: r});
        tick();
        req_valid = 1'b0;
    endtask

    task automatic wait_rsp(input int max);
        int n = 0;
        while (rsp_valid !== 1'b1 && n < max) begin
            tick();
            n++;
        end
        chk("rsp_arrival", 32'(rsp_valid), 32'd1);
    endtask

    task automatic sb_check(input string tag);
        exp_t e;
        chk({tag, "_sb_nonempty"}, 32'(sb.size() != 0), 32'd1);
        if (sb.size() != 0) begin
            e = sb.pop_front();
            chk({tag, "_err"}, 32'(rsp_err), 32'(e.err));
            chk({tag, "_rdata"}, rsp_rdata, e.rdata);
        end
    endtask

    task automatic accept();
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        chk("acc_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("acc_req_ready", 32'(req_ready), 32'd1);
    endtask

    initial begin
        int n_en;
        tick();
        tick();
        rst = 1'b0;
        chk("rst_req_ready", 32'(req_ready), 32'd1);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_sel", 32'(apb_sel), 32'd0);
        chk("rst_enable", 32'(apb_enable), 32'd0);
        chk("rst_rdata", rsp_rdata, 32'd0);
        chk("rst_err", 32'(rsp_err), 32'd0);

        // write, slave ready immediately (ready high also during IDLE/SETUP, which must be ignored)
        apb_ready = 1'b1;
        req(2'd0, 5'h04, 1'b1, 32'hDEADBEEF, 1'b0, 32'h0, 1'b1);
        chk("wr_setup_sel", 32'(apb_sel), 32'd1);
        chk("wr_setup_en", 32'(apb_enable), 32'd0);
        chk("wr_setup_addr", 32'(apb_addr), 32'h04);
        chk("wr_setup_dir", 32'(apb_wr_rd), 32'd1);
        chk("wr_setup_wdata", apb_wdata, 32'hDEADBEEF);
        chk("wr_setup_req_ready", 32'(req_ready), 32'd0);
        tick();
        chk("wr_access_en", 32'(apb_enable), 32'd1);
        chk("wr_access_sel", 32'(apb_sel), 32'd1);
        tick();
        chk("wr_rsp_valid", 32'(rsp_valid), 32'd1);
        chk("wr_rsp_sel", 32'(apb_sel), 32'd0);
        chk("wr_rsp_en", 32'(apb_enable), 32'd0);
        sb_check("wr");
        accept();

        // read with three wait cycles
        apb_ready = 1'b0;
        req(2'd1, 5'h08, 1'b0, 32'h0, 1'b0, 32'h12345678, 1'b1);
        chk("rd_setup_sel", 32'(apb_sel), 32'd2);
        chk("rd_setup_en", 32'(apb_enable), 32'd0);
        tick();
        for (int i = 0; i < 3; i++) begin
            chk("rd_wait_en", 32'(apb_enable), 32'd1);
            chk("rd_wait_sel", 32'(apb_sel), 32'd2);
            chk("rd_wait_addr", 32'(apb_addr), 32'h08);
            chk("rd_wait_dir", 32'(apb_wr_rd), 32'd0);
            chk("rd_wait_rsp_valid", 32'(rsp_valid), 32'd0);
            tick();
        end
        chk("rd_last_en", 32'(apb_enable), 32'd1);
        apb_ready = 1'b1;
        apb_rdata = 32'h12345678;
        tick();
        apb_ready = 1'b0;
        apb_rdata = '0;
        chk("rd_rsp_valid", 32'(rsp_valid), 32'd1);
        sb_check("rd");
        accept();

        // bad slave index: no bus cycle, error one cycle after handshake
        req(2'd3, 5'h01, 1'b0, 32'h0, 1'b1, 32'h0, 1'b1);
        chk("bad_rsp_valid", 32'(rsp_valid), 32'd1);
        chk("bad_sel", 32'(apb_sel), 32'd0);
        chk("bad_en", 32'(apb_enable), 32'd0);
        sb_check("bad");
        accept();

        // backpressure with a competing request held high
        apb_ready = 1'b1;
        apb_rdata = 32'hA5A50F0F;
        req(2'd2, 5'h1F, 1'b0, 32'h0, 1'b0, 32'hA5A50F0F, 1'b1);
        tick();
        tick();
        apb_rdata = '0;
        req_valid = 1'b1;
        req_slave = 2'd0;
        req_addr  = 5'h02;
        req_wr_rd = 1'b1;
        req_wdata = 32'h0BADF00D;
        for (int i = 0; i < 5; i++) begin
            chk("bp_rsp_valid", 32'(rsp_valid), 32'd1);
            chk("bp_rsp_rdata", rsp_rdata, 32'hA5A50F0F);
            chk("bp_req_ready", 32'(req_ready), 32'd0);
            chk("bp_sel", 32'(apb_sel), 32'd0);
            tick();
        end
        sb_check("bp");
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        chk("bp_done_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("bp_done_req_ready", 32'(req_ready), 32'd1);
        chk("bp_done_sel", 32'(apb_sel), 32'd0);
        sb.push_back('{err: 1'b0, rdata: 32'h0});
        tick();
        req_valid = 1'b0;
        chk("bp_next_sel", 32'(apb_sel), 32'd1);
        chk("bp_next_wdata", apb_wdata, 32'h0BADF00D);
        tick();
        tick();
        chk("bp_next_rsp_valid", 32'(rsp_valid), 32'd1);
        sb_check("bp_next");
        accept();

`ifdef DBG_APB_MASTER_TIMEOUT_EN
        // slave never ready: exactly TO enable cycles, then error
        apb_ready = 1'b0;
        req(2'd0, 5'h03, 1'b0, 32'h0, 1'b1, 32'h0, 1'b1);
        n_en = 0;
        for (int i = 0; i < 20 && rsp_valid !== 1'b1; i++) begin
            if (apb_enable === 1'b1) n_en++;
            tick();
        end
        chk("to_enable_cycles", 32'(n_en), 32'(TO));
        chk("to_rsp_valid", 32'(rsp_valid), 32'd1);
        sb_check("to");
        accept();
        // ready on the last allowed cycle counts as success
        req(2'd0, 5'h03, 1'b0, 32'h0, 1'b0, 32'h00000077, 1'b1);
        for (int i = 0; i < TO; i++) tick();
        chk("to_edge_en", 32'(apb_enable), 32'd1);
        apb_ready = 1'b1;
        apb_rdata = 32'h00000077;
        tick();
        apb_ready = 1'b0;
        apb_rdata = '0;
        chk("to_edge_rsp_valid", 32'(rsp_valid), 32'd1);
        sb_check("to_edge");
        accept();
`else
        // without the timeout the bridge waits well beyond any counter limit
        apb_ready = 1'b0;
        req(2'd1, 5'h06, 1'b0, 32'h0, 1'b0, 32'h5A5A5A5A, 1'b1);
        n_en = 0;
        for (int i = 0; i < 80; i++) tick();
        chk("long_wait_en", 32'(apb_enable), 32'd1);
        chk("long_wait_rsp_valid", 32'(rsp_valid), 32'd0);
        apb_ready = 1'b1;
        apb_rdata = 32'h5A5A5A5A;
        tick();
        apb_ready = 1'b0;
        apb_rdata = '0;
        chk("long_rsp_valid", 32'(rsp_valid), 32'd1);
        sb_check("long");
        accept();
`endif

        // reset during ACCESS aborts without a response
        apb_ready = 1'b0;
        req(2'd1, 5'h09, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        tick();
        chk("rstmid_en_before", 32'(apb_enable), 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rstmid_sel", 32'(apb_sel), 32'd0);
        chk("rstmid_en", 32'(apb_enable), 32'd0);
        chk("rstmid_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rstmid_req_ready", 32'(req_ready), 32'd1);
        tick();
        tick();
        chk("rstmid_no_rsp", 32'(rsp_valid), 32'd0);
        apb_ready = 1'b1;
        apb_rdata = 32'hCAFEF00D;
        req(2'd1, 5'h09, 1'b0, 32'h0, 1'b0, 32'hCAFEF00D, 1'b1);
        chk("post_rst_sel", 32'(apb_sel), 32'd2);
        wait_rsp(5);
        apb_ready = 1'b0;
        apb_rdata = '0;
        sb_check("post_rst");
        accept();

        chk("sb_drained", 32'(sb.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/dbg_apb_master.md
Name: dbg_apb_master

Overview:
- Debug APB master bridge; sits directly downstream of the DAP memory interface and directly upstream of the debug APB bus / per-core CoreDbgApb slaves.
- Accepts one simple request at a time (slave index, addr, direction, wdata) and sequences the APB SETUP/ACCESS phases: sel, enable, ready wait, rdata capture.
- Returns a response (rdata, error) to the DAP; drives the enable signal the DAP does not produce itself.

Parameters:
- NR_SLAVES, 1, number of APB slaves (cores); width of one-hot sel.
- ADDR_WIDTH, 5, APB address width.
- WDATA_WIDTH, 32, APB write data width.
- RDATA_WIDTH, 32, APB read data width.
- TIMEOUT_CYCLES, 64, max ACCESS cycles with ready low before abort (used only with the macro; legal range 1..65535).
- SLV_W, $clog2(NR_SLAVES) with a minimum of 1, width of the slave index (derived localparam).

Ports:
- clk  in  1  single clock; all logic on rising edge.
- rst  in  1  reset, synchronous, active-high.
- req_valid  in  1  request present.
- req_ready  out  1  bridge can accept; high only in IDLE.
- req_slave  in  SLV_W  target slave index.
- req_addr  in  ADDR_WIDTH  register address.
- req_wr_rd  in  1  1 = write, 0 = read.
- req_wdata  in  WDATA_WIDTH  write data.
- rsp_valid  out  1  response available; held until accepted.
- rsp_ready  in  1  DAP accepts response.
- rsp_rdata  out  RDATA_WIDTH  captured read data; 0 for writes and errors.
- rsp_err  out  1  1 = bad slave index or timeout.
- apb_addr  out  ADDR_WIDTH  APB address.
- apb_sel  out  NR_SLAVES  one-hot slave select.
- apb_enable  out  1  ACCESS phase indicator.
- apb_wr_rd  out  1  APB direction.
- apb_wdata  out  WDATA_WIDTH  APB write data.
- apb_ready  in  1  slave ready (from bus mux).
- apb_rdata  in  RDATA_WIDTH  read data (from bus mux).

Behaviour:
- Reset (sync, rst=1 at edge): state IDLE; req_ready=1 after the reset edge; all other outputs 0; timeout counter 0.
- Reset asserted mid-transfer aborts the transfer: sel/enable drop at that edge and no response is produced.
- All APB outputs and rsp_* outputs are registered.
- FSM states: IDLE, SETUP, ACCESS, RESP.
- IDLE:
  - Handshake when req_valid && req_ready; the bridge latches slave, addr, wr_rd and wdata.
  - If req_slave >= NR_SLAVES: go to RESP with rsp_err=1, rsp_rdata=0; no bus cycle.
  - Otherwise go to SETUP.
- SETUP (one cycle): apb_sel[slave]=1, apb_enable=0, addr/wr_rd/wdata valid and stable; then go to ACCESS.
- ACCESS:
  - apb_enable=1; sel, addr, wr_rd and wdata are unchanged.
  - apb_ready=1 sampled: if read, capture apb_rdata into rsp_rdata, else rsp_rdata=0; rsp_err=0; go to RESP.
  - apb_ready=0: stay in ACCESS.
- RESP:
  - sel=0, enable=0; rsp_valid=1 held with stable data until rsp_ready.
  - On rsp_valid && rsp_ready: go to IDLE; rsp_valid=0 next cycle.
  - rsp_ready is ignored outside RESP.
- Latency: request handshake at cycle N; SETUP at N+1; ACCESS at N+2; with ready=1 at N+2, rsp_valid=1 at N+3.
- Throughput: the next req_ready=1 comes one cycle after the response handshake (no overlap).
- apb_ready is ignored in IDLE, SETUP and RESP.
- Exactly one sel bit high in SETUP/ACCESS; all zero otherwise.

Optional Feature:
- Macro: DBG_APB_MASTER_TIMEOUT_EN.
- Defined: the counter clears on entry to ACCESS and increments on each ACCESS cycle with apb_ready=0.
  - If ready is still low on ACCESS cycle TIMEOUT_CYCLES (counting from 1), the transfer aborts and goes to RESP with rsp_err=1, rsp_rdata=0.
  - Ready=1 on that same cycle counts as success, not timeout.
- Undefined: no counter logic; ACCESS waits indefinitely; rsp_err comes only from a bad slave index.

Decomposition:
- Package dbg_apb_pkg:
  - enum dbg_apb_state_e {IDLE, SETUP, ACCESS, RESP};
  - localparam RSP_OK=0, RSP_ERR=1;
  - function onehot(idx, n) for sel generation.
- Sub-module dbg_apb_timeout_cnt: clear/inc/expired, parameter TIMEOUT_CYCLES, counter width $clog2(TIMEOUT_CYCLES+1). Instantiated only under the macro.

Test Plan:
- Write: slave 0, addr 5'h04, wdata 32'hDEADBEEF, ready=1 immediately.
  -> sel=1/enable=0 at N+1; enable=1 at N+2; rsp_valid at N+3; rsp_err=0, rsp_rdata=0.
- Read: addr 5'h08, slave holds ready=0 for 3 ACCESS cycles, then ready=1 with rdata 32'h12345678.
  -> addr, sel and wr_rd stable throughout; rsp_rdata=32'h12345678 at the cycle after ready.
- Bad index: NR_SLAVES=3, req_slave=3.
  -> apb_sel stays 0; rsp_valid one cycle after handshake; rsp_err=1.
- Backpressure: rsp_ready=0 for 5 cycles.
  -> rsp_valid and rsp_rdata held; req_ready=0; new req_valid is ignored until the cycle after rsp_ready=1.
- Timeout (macro on, TIMEOUT_CYCLES=4, ready never asserted).
  -> exactly 4 enable=1 cycles, then RESP with rsp_err=1. Repeat with ready=1 on the 4th cycle -> rsp_err=0.
- Reset during ACCESS.
  -> sel and enable are 0 after the reset edge; no rsp_valid; the next request completes normally.
